// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, condition and write-data-select encodings
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_BRANCH  = 3'd5
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluation against NZCV
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      // NV is reserved and never executes
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle instruction control FSM with retired-instruction counter
module multicycle_sequencer
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  op,
  input  logic [3:0]  cond,
  input  logic [3:0]  flags,
  input  logic        s_bit,
  input  logic        l_bit,
  input  logic        bl_bit,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        regfile_WE,
  output logic        datamem_WE,
  output logic        flags_WE,
  output logic        alu_src_select,
  output logic        datamem_addr_select,
  output logic [1:0]  regfile_WD_select,
  output logic        mem_req,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        cond_pass;
  logic        passed;
  logic        retire;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Undefined instructions fall through exactly like a failed condition
  assign passed = cond_pass && (op != OP_UND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    ir_we               = 1'b0;
    pc_we               = 1'b0;
    regfile_WE          = 1'b0;
    datamem_WE          = 1'b0;
    flags_WE            = 1'b0;
    alu_src_select      = 1'b0;
    datamem_addr_select = 1'b0;
    regfile_WD_select   = WD_ALU;
    mem_req             = 1'b0;
    retire              = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (!passed) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_BR) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_src_select = 1'b1;
        if (op == OP_DP) begin
          flags_WE = s_bit;
          state_d  = S_WB;
        end else if (op == OP_MEM) begin
          state_d  = S_MEM;
        end else begin
          state_d  = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req             = 1'b1;
        datamem_addr_select = 1'b1;
        // The only Mealy output: a store writes in the cycle the memory accepts it
        datamem_WE          = ~l_bit & mem_ready;
        if (mem_ready) begin
          if (l_bit) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        regfile_WE        = 1'b1;
        regfile_WD_select = (op == OP_MEM) ? WD_MEM : WD_ALU;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end

      S_BRANCH: begin
        pc_we          = 1'b1;
        alu_src_select = 1'b1;
        retire         = 1'b1;
        if (bl_bit) begin
          regfile_WE        = 1'b1;
          regfile_WD_select = WD_PC4;
        end
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + {31'd0, retire};
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 The block SHALL have these ports: rst  in  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-003 The block SHALL have these ports: op  in  2  decoded instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-004 The block SHALL have these ports: cond  in  4  instruction condition field; flags  in  4  registered NZCV (bit3 = N).
REQ-005 The block SHALL have these ports: s_bit  in  1  set-flags bit; l_bit  in  1  load(1)/store(0); bl_bit  in  1  branch-with-link.
REQ-006 The block SHALL have these ports: mem_ready  in  1  data-memory access complete.
REQ-007 The block SHALL have these ports: ir_we, pc_we, regfile_WE, datamem_WE, flags_WE  out  1 each  one-cycle write strobes.
REQ-008 The block SHALL have these ports: alu_src_select  out  1  (1 = immediate); datamem_addr_select  out  1; regfile_WD_select  out  2  (0 ALU, 1 memory, 2 PC+4).
REQ-009 The block SHALL have these ports: mem_req  out  1  data-memory request; state  out  3  current state code; retired  out  32  retired-instruction counter.

Function
REQ-010 The states SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, BRANCH=5.
REQ-011 FETCH SHALL assert ir_we and pc_we for exactly one cycle, then go to DECODE.
REQ-012 DECODE SHALL evaluate cond against flags per ARM encoding 0000 EQ … 1110 AL; 1111 SHALL count as not-passed.
REQ-013 A condition that is not passed SHALL send DECODE to FETCH with no write strobe asserted, and the instruction SHALL still count as retired.
REQ-014 A condition that is passed SHALL send DECODE to EXECUTE for op 00/01 and to BRANCH for op 10.
REQ-015 Op 11 SHALL be treated as not-passed.
REQ-016 EXECUTE SHALL go to WB for op 00 and to MEM for op 01.
REQ-017 For op 00, flags_WE SHALL be asserted in EXECUTE when s_bit=1.
REQ-018 MEM SHALL hold mem_req=1 and datamem_addr_select=1 until mem_ready=1.
REQ-019 During MEM with l_bit=0, datamem_WE SHALL equal mem_ready, giving a single write pulse.
REQ-020 When mem_ready=1 in MEM, the next state SHALL be WB for a load and FETCH for a store.
REQ-021 mem_ready arriving in the same cycle that MEM is entered SHALL complete the access in that cycle, so MEM lasts at least one cycle.
REQ-022 A mem_ready that is high outside MEM SHALL be ignored.
REQ-023 WB SHALL assert regfile_WE for one cycle, with regfile_WD_select=0 for op 00 and 1 for a load, then go to FETCH.
REQ-024 BRANCH SHALL assert pc_we for one cycle and go to FETCH.
REQ-025 In BRANCH, when bl_bit=1, the block SHALL also assert regfile_WE with regfile_WD_select=2 in the same cycle.
REQ-026 alu_src_select SHALL be 1 in EXECUTE and BRANCH, and 0 otherwise.
REQ-027 All control outputs SHALL be Moore or registered-state decodes; only datamem_WE may depend combinationally on mem_ready.
REQ-028 retired SHALL increment by 1 on the final cycle of each instruction: WB, BRANCH, a store completion, or a not-passed DECODE.
REQ-029 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 Instruction latency SHALL be 4 cycles for DP, 5+w for a load, 4+w for a store, 3 for a branch, and 2 for a not-passed instruction, where w = wait cycles.

Reset
REQ-031 rst=1 at a clock edge SHALL force state to FETCH, clear retired to 0, and deassert all strobes and mem_req in the following cycle.
REQ-032 rst SHALL take priority over every transition, including MEM waiting on mem_ready.
REQ-033 Reset asserted during MEM SHALL abandon the access with no datamem_WE pulse after the reset edge.

Structure
REQ-034 The state enum, the op encodings and the cond codes SHALL live in the shared package mc_pkg.
REQ-035 Condition evaluation SHALL be a combinational sub-module cond_check (inputs cond and flags, output pass).
REQ-036 The state register and the counter SHALL be the only sequential elements.

Verification
REQ-037 The bench SHALL run: reset, then ADD with cond=1110, s_bit=1 -> states 0,1,2,4,0, flags_WE high in cycle 2, regfile_WE high in cycle 3, retired=1.
REQ-038 The bench SHALL run: LDR with mem_ready low for 3 cycles -> MEM held 4 cycles, WB with regfile_WD_select=1, total 8 cycles.
REQ-039 The bench SHALL run: STR with mem_ready=1 immediately -> exactly one datamem_WE pulse, regfile_WE never high, back to FETCH after 4 cycles.
REQ-040 The bench SHALL run: BEQ with flags=0000 -> DECODE to FETCH, no pc_we in DECODE, retired increments.
REQ-041 The bench SHALL run the same BEQ with flags=0100 -> BRANCH taken; then BL -> regfile_WE with regfile_WD_select=2 in the same cycle as pc_we.
REQ-042 The bench SHALL run: rst pulsed while in MEM with mem_ready low -> state=0 next cycle, retired=0, no datamem_WE.
